// File: rtl/shift_pkg.sv
// ============================================================================
// Module      : shift_pkg
// Description : Shared opcode and FSM state types for the iterative shift unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_pkg;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_ROR = 2'b10,
    SHIFT_SRA = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } shift_state_e;

endpackage

`default_nettype wire

// File: rtl/shift_step.sv
// ============================================================================
// Module      : shift_step
// Description : Combinational single step of the iterative shifter (k <= STEP).
//               SHIFT_ROTATE_EN enables ROR for op 2'b10; otherwise it acts as SRL.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_step
  import shift_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int KW   = 6
) (
  input  logic [XLEN-1:0] acc_i,
  input  shift_op_e       op_i,
  input  logic [KW-1:0]   k_i,
  output logic [XLEN-1:0] acc_o
);

`ifdef SHIFT_ROTATE_EN
  // k == 0 yields a left shift of XLEN, which clears the wrapped half.
  logic [KW-1:0] w_ror_lsh;
  assign w_ror_lsh = KW'(XLEN) - k_i;
`endif

  always_comb begin
    acc_o = acc_i;
    case (op_i)
      SHIFT_SLL: acc_o = acc_i << k_i;
      SHIFT_SRA: acc_o = XLEN'($signed(acc_i) >>> k_i);
`ifdef SHIFT_ROTATE_EN
      SHIFT_ROR: acc_o = (acc_i >> k_i) | (acc_i << w_ror_lsh);
`endif
      default:   acc_o = acc_i >> k_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/iterative_shift_unit.sv
// ============================================================================
// Module      : iterative_shift_unit
// Description : Multi-cycle SLL/SRL/SRA (ROR with SHIFT_ROTATE_EN) unit, STEP
//               bits per cycle, valid/ready on both request and result sides.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iterative_shift_unit
  import shift_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 1,
  localparam int SHAMT_W = $clog2(XLEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_op,
  input  logic [XLEN-1:0]    in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_data,
  output logic               busy
);

  localparam logic [SHAMT_W:0] c_STEP = (SHAMT_W+1)'(STEP);

  shift_state_e         state_q, state_d;
  shift_op_e            op_q, op_d;
  logic [XLEN-1:0]      acc_q, acc_d;
  logic [SHAMT_W-1:0]   rem_q, rem_d;

  logic [SHAMT_W:0]     w_rem_ext;
  logic [SHAMT_W:0]     w_k;
  logic [SHAMT_W-1:0]   w_rem_next;
  logic [XLEN-1:0]      w_step_acc;

  // k never exceeds rem, so the counter cannot wrap below zero.
  assign w_rem_ext  = {1'b0, rem_q};
  assign w_k        = (w_rem_ext < c_STEP) ? w_rem_ext : c_STEP;
  assign w_rem_next = rem_q - w_k[SHAMT_W-1:0];

  shift_step #(
    .XLEN (XLEN),
    .KW   (SHAMT_W + 1)
  ) u_step (
    .acc_i (acc_q),
    .op_i  (op_q),
    .k_i   (w_k),
    .acc_o (w_step_acc)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = shift_op_e'(in_op);
          acc_d   = in_data;
          rem_d   = in_shamt;
          state_d = (in_shamt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        acc_d = w_step_acc;
        rem_d = w_rem_next;
        if (w_rem_next == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= SHIFT_SLL;
      acc_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_valid ? acc_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_iterative_shift_unit.sv
// ============================================================================
// Module      : tb_iterative_shift_unit
// Description : Self-checking bench; STEP=1 and STEP=8 instances run in lockstep.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iterative_shift_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, out_ready;
  logic [1:0]  in_op;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;

  logic        in_ready1, out_valid1, busy1;
  logic [31:0] out_data1;
  logic        in_ready8, out_valid8, busy8;
  logic [31:0] out_data8;

  int n_cmp = 0;
  int n_err = 0;

  always #1 clk = ~clk;

  iterative_shift_unit #(.XLEN(32), .STEP(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .in_op(in_op), .in_data(in_data), .in_shamt(in_shamt),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .busy(busy1)
  );

  iterative_shift_unit #(.XLEN(32), .STEP(8)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready8),
    .in_op(in_op), .in_data(in_data), .in_shamt(in_shamt),
    .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8), .busy(busy8)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    int          shamt;
    logic [31:0] exp;
    int          lat1;
    int          lat8;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: shifts as multiply/divide by powers of two on 64-bit integers.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] d, input int s);
    longint unsigned v = {32'd0, d};
    longint unsigned p = 64'd1 << s;
    longint unsigned w = 64'd1 << 32;
    longint unsigned r;
    case (op)
      2'b00:   r = (v * p) % w;
      2'b01:   r = v / p;
      2'b11:   r = v / p + (d[31] ? (w - w / p) : 64'd0);
`ifdef SHIFT_ROTATE_EN
      default: r = v / p + (v % p) * (w / p);
`else
      default: r = v / p;
`endif
    endcase
    return r[31:0];
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] data, input int shamt,
                        output logic [31:0] d1, output logic [31:0] d8,
                        output int l1, output int l8);
    logic stable;
    d1 = 'x; d8 = 'x; l1 = 0; l8 = 0; stable = 1'b1;
    in_op = op; in_data = data; in_shamt = shamt[4:0]; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 1; c < 200; c++) begin
      if (l8 != 0 && out_data8 !== d8) stable = 1'b0;
      if (out_valid1 && l1 == 0) begin l1 = c; d1 = out_data1; end
      if (out_valid8 && l8 == 0) begin l8 = c; d8 = out_data8; end
      if (l1 != 0 && l8 != 0) break;
      @(posedge clk); #1;
    end
    if (l1 == 0 || l8 == 0) begin
      n_cmp++; n_err++;
      $display("FAIL timeout: got l1=%0d l8=%0d expected both nonzero", l1, l8);
    end
    chk("hold_stable8", {31'd0, stable}, 32'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("drain_in_ready1", {31'd0, in_ready1}, 32'd1);
    chk("drain_out_valid8", {31'd0, out_valid8}, 32'd0);
  endtask

  initial begin
    logic [31:0] d1, d8, e;
    int l1, l8, sh;
    logic [1:0] op;
    logic seen;

    vt[0] = '{2'b11, 32'h0000_0040,  4, 32'h0000_0004,  5, 2};
    vt[1] = '{2'b11, 32'h8000_0000,  4, 32'hF800_0000,  5, 2};
    vt[2] = '{2'b01, 32'h8000_0000,  4, 32'h0800_0000,  5, 2};
    vt[3] = '{2'b00, 32'h0000_0001, 31, 32'h8000_0000, 32, 5};
    vt[4] = '{2'b11, 32'hDEAD_BEEF,  0, 32'hDEAD_BEEF,  1, 1};
    vt[5] = '{2'b00, 32'hDEAD_BEEF,  0, 32'hDEAD_BEEF,  1, 1};
    vt[6] = '{2'b11, 32'h8000_0000, 19, 32'hFFFF_F000, 20, 4};
`ifdef SHIFT_ROTATE_EN
    vt[7] = '{2'b10, 32'h0000_0001,  1, 32'h8000_0000,  2, 2};
`else
    vt[7] = '{2'b10, 32'h0000_0001,  1, 32'h0000_0000,  2, 2};
`endif

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_op = 2'b00; in_data = '0; in_shamt = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid1", {31'd0, out_valid1}, 32'd0);
    chk("rst_out_data1", out_data1, 32'd0);
    chk("rst_busy8", {31'd0, busy8}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready1", {31'd0, in_ready1}, 32'd1);
    chk("rst_in_ready8", {31'd0, in_ready8}, 32'd1);

    for (int i = 0; i < 8; i++) begin
      run_op(vt[i].op, vt[i].data, vt[i].shamt, d1, d8, l1, l8);
      chk($sformatf("vec%0d_data1", i), d1, vt[i].exp);
      chk($sformatf("vec%0d_data8", i), d8, vt[i].exp);
      chk($sformatf("vec%0d_lat1", i), l1, vt[i].lat1);
      chk($sformatf("vec%0d_lat8", i), l8, vt[i].lat8);
      drain();
    end

    // Back-pressure: result held while a second request is offered and ignored.
    run_op(2'b01, 32'h0000_00F0, 4, d1, d8, l1, l8);
    chk("bp_first_data1", d1, 32'h0000_000F);
    in_valid = 1'b1; in_data = 32'h1234_5678; in_shamt = 5'd0; in_op = 2'b00;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid1", {31'd0, out_valid1}, 32'd1);
      chk("bp_out_data1", out_data1, 32'h0000_000F);
      chk("bp_in_ready1", {31'd0, in_ready1}, 32'd0);
      chk("bp_out_data8", out_data8, 32'h0000_000F);
    end
    in_valid = 1'b0;
    drain();
    @(posedge clk); #1;
    chk("bp_after_busy1", {31'd0, busy1}, 32'd0);
    chk("bp_after_busy8", {31'd0, busy8}, 32'd0);

    // Reset mid-operation discards the result.
    in_op = 2'b00; in_data = 32'h0000_00A5; in_shamt = 5'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy1", {31'd0, busy1}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_out_valid1", {31'd0, out_valid1}, 32'd0);
    chk("abort_busy1", {31'd0, busy1}, 32'd0);
    chk("abort_in_ready1", {31'd0, in_ready1}, 32'd1);
    chk("abort_out_valid8", {31'd0, out_valid8}, 32'd0);
    chk("abort_in_ready8", {31'd0, in_ready8}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid1 || out_valid8 || busy1 || busy8) seen = 1'b1;
    end
    chk("abort_no_result", {31'd0, seen}, 32'd0);

    // Randomized operations against the arithmetic reference.
    for (int i = 0; i < 150; i++) begin
      op = 2'($urandom_range(0, 3));
      sh = int'($urandom_range(0, 31));
      in_data = $urandom;
      e = model(op, in_data, sh);
      run_op(op, in_data, sh, d1, d8, l1, l8);
      chk("rand_data1", d1, e);
      chk("rand_data8", d8, e);
      chk("rand_lat1", l1, 1 + sh);
      chk("rand_lat8", l8, 1 + (sh + 7) / 8);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
